pcpi_initiator: RTL and testbench

PCPI_INITIATOR -- requirements
Module: pcpi_initiator

---
 rtl/pcpi_pkg.sv | 28 ++
 rtl/pcpi_watchdog.sv | 35 +++
 rtl/pcpi_initiator.sv | 186 ++++++++++++++++++
 tb/tb_pcpi_initiator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_pkg
// Description : Shared PCPI constants, FSM state type and insn-word builder.
// Revision    : 1.0  initial release
// ============================================================================
package pcpi_pkg;

    localparam logic [6:0] c_OPCODE_OP  = 7'b0110011;
    localparam logic [6:0] c_FUNCT7_MUL = 7'b0000001;
    localparam logic [4:0] c_RS1_IDX    = 5'd1;
    localparam logic [4:0] c_RS2_IDX    = 5'd2;
    localparam int         c_TMO_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DELIVER   = 2'd3
    } pcpi_state_t;

    function automatic logic [31:0] pcpi_make_insn(input logic [2:0] funct3,
                                                   input logic [4:0] rd);
        return {c_FUNCT7_MUL, c_RS2_IDX, c_RS1_IDX, funct3, rd, c_OPCODE_OP};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcpi_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_watchdog
// Description : Response-wait cycle counter; expired is high on the
//               TIMEOUT_CYCLES-th enabled cycle since the last clear.
// Revision    : 1.0  initial release
// ============================================================================
module pcpi_watchdog
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [c_TMO_W-1:0] c_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pcpi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : pcpi_initiator
// Description : Command-to-PCPI bridge: issues one PCPI request per command,
//               waits for ready and hands the result to a consumer.
//               Optional response timeout enabled by macro PCPI_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pcpi_initiator
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_STB,
    input  logic [2:0]  cmd_funct3,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    output logic        cmd_BUSY,
    output logic        pico_valid,
    output logic [31:0] pico_insn,
    output logic [31:0] pico_rs1,
    output logic [31:0] pico_rs2,
    input  logic        pico_wr,
    input  logic [31:0] pico_rd,
    input  logic        pico_wait,
    input  logic        pico_ready,
    output logic        res_STB,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_wr,
    output logic        res_err,
    input  logic        res_BUSY
);

    pcpi_state_t r_state, w_state_nxt;

    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_rs1, r_rs2;

    logic        w_capture;
    logic        w_timeout;
    logic        w_cmd_busy, w_valid, w_res_stb, w_res_wr, w_res_err;
    logic [31:0] w_insn, w_rs1, w_rs2, w_res_data;
    logic [4:0]  w_res_rd;

    // The wait hint is informational only; the FSM never consults it.
    logic w_unused_wait;
    assign w_unused_wait = pico_wait;

`ifdef PCPI_TIMEOUT_EN
    logic w_wd_clear, w_wd_enable;
    assign w_wd_clear  = (r_state == ST_ISSUE);
    assign w_wd_enable = (r_state == ST_WAIT_RESP);

    pcpi_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_timeout)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3 <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
        end else if (w_capture) begin
            r_funct3 <= cmd_funct3;
            r_rd     <= cmd_rd;
            r_rs1    <= cmd_rs1;
            r_rs2    <= cmd_rs2;
        end
    end

    // Every output is a register loaded from its next-value wire below.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cmd_busy  = cmd_BUSY;
        w_valid     = pico_valid;
        w_insn      = pico_insn;
        w_rs1       = pico_rs1;
        w_rs2       = pico_rs2;
        w_res_stb   = res_STB;
        w_res_data  = res_data;
        w_res_rd    = res_rd;
        w_res_wr    = res_wr;
        w_res_err   = res_err;

        case (r_state)
            ST_IDLE: begin
                if (cmd_STB) begin
                    w_capture   = 1'b1;
                    w_cmd_busy  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_valid     = 1'b1;
                w_insn      = pcpi_make_insn(r_funct3, r_rd);
                w_rs1       = r_rs1;
                w_rs2       = r_rs2;
                w_state_nxt = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // Ready has priority over a coincident expiry.
                if (pico_ready) begin
                    w_valid     = 1'b0;
                    w_res_stb   = 1'b1;
                    w_res_data  = pico_rd;
                    w_res_rd    = r_rd;
                    w_res_wr    = pico_wr;
                    w_res_err   = 1'b0;
                    w_state_nxt = ST_DELIVER;
                end else if (w_timeout) begin
                    w_valid     = 1'b0;
                    w_res_stb   = 1'b1;
                    w_res_data  = '0;
                    w_res_rd    = r_rd;
                    w_res_wr    = 1'b0;
                    w_res_err   = 1'b1;
                    w_state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (res_STB && res_BUSY) begin
                    w_res_stb   = 1'b0;
                    w_cmd_busy  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_BUSY   <= 1'b0;
            pico_valid <= 1'b0;
            pico_insn  <= '0;
            pico_rs1   <= '0;
            pico_rs2   <= '0;
            res_STB    <= 1'b0;
            res_data   <= '0;
            res_rd     <= '0;
            res_wr     <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            cmd_BUSY   <= w_cmd_busy;
            pico_valid <= w_valid;
            pico_insn  <= w_insn;
            pico_rs1   <= w_rs1;
            pico_rs2   <= w_rs2;
            res_STB    <= w_res_stb;
            res_data   <= w_res_data;
            res_rd     <= w_res_rd;
            res_wr     <= w_res_wr;
            res_err    <= w_res_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcpi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcpi_initiator
// Description : Randomized self-checking bench; the bench plays producer,
//               PCPI responder and consumer against a transaction-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pcpi_initiator;

    localparam int TMO = 16;
`ifdef PCPI_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam bit c_TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_STB;
    logic [2:0]  cmd_funct3;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_rs1, cmd_rs2;
    logic        cmd_BUSY;
    logic        pico_valid;
    logic [31:0] pico_insn, pico_rs1, pico_rs2;
    logic        pico_wr;
    logic [31:0] pico_rd;
    logic        pico_wait;
    logic        pico_ready;
    logic        res_STB;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_wr;
    logic        res_err;
    logic        res_BUSY;

    int n_vec = 0;
    int n_err = 0;

    pcpi_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_STB    (cmd_STB),
        .cmd_funct3 (cmd_funct3),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_BUSY   (cmd_BUSY),
        .pico_valid (pico_valid),
        .pico_insn  (pico_insn),
        .pico_rs1   (pico_rs1),
        .pico_rs2   (pico_rs2),
        .pico_wr    (pico_wr),
        .pico_rd    (pico_rd),
        .pico_wait  (pico_wait),
        .pico_ready (pico_ready),
        .res_STB    (res_STB),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_wr     (res_wr),
        .res_err    (res_err),
        .res_BUSY   (res_BUSY)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // R-type PCPI word: funct7=1, rs2=x2, rs1=x1, custom funct3/rd, OP opcode.
    function automatic logic [31:0] model_insn(input logic [2:0] f3, input logic [4:0] rd);
        return (32'd1 << 25) + (32'd2 << 20) + (32'd1 << 15)
             + (32'(f3) << 12) + (32'(rd) << 7) + 32'h33;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  32'(cmd_BUSY),   32'd0);
        check_eq({tag, "_valid"}, 32'(pico_valid), 32'd0);
        check_eq({tag, "_insn"},  pico_insn,       32'd0);
        check_eq({tag, "_rs1"},   pico_rs1,        32'd0);
        check_eq({tag, "_rs2"},   pico_rs2,        32'd0);
        check_eq({tag, "_stb"},   32'(res_STB),    32'd0);
        check_eq({tag, "_data"},  res_data,        32'd0);
        check_eq({tag, "_rd"},    32'(res_rd),     32'd0);
        check_eq({tag, "_wr"},    32'(res_wr),     32'd0);
        check_eq({tag, "_err"},   32'(res_err),    32'd0);
    endtask

    // One full command: d = responder wait cycles before ready,
    // ack_d = cycles the consumer stalls before taking the result.
    task automatic run_txn(input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input int d, input logic wr, input logic [31:0] rdata,
                           input int ack_d, input bit ready_in_issue);
        logic [31:0] e_insn;
        logic [31:0] e_data;
        logic        e_wr, e_err;
        bit          e_to;
        e_insn = model_insn(f3, rd);
        e_to   = c_TMO_EN && (d >= TMO);
        e_data = e_to ? 32'd0 : rdata;
        e_wr   = e_to ? 1'b0 : wr;
        e_err  = e_to;

        cmd_STB = 1'b1; cmd_funct3 = f3; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        @(negedge clk);
        check_eq("accept_busy", 32'(cmd_BUSY), 32'd1);
        check_eq("accept_no_valid", 32'(pico_valid), 32'd0);
        cmd_STB = 1'b0;
        cmd_funct3 = 3'($urandom); cmd_rd = 5'($urandom);
        cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        pico_ready = ready_in_issue;
        pico_wr = 1'b1; pico_rd = $urandom;
        @(negedge clk);
        pico_ready = 1'b0;
        check_eq("issue_valid", 32'(pico_valid), 32'd1);
        check_eq("issue_insn", pico_insn, e_insn);
        check_eq("issue_rs1", pico_rs1, rs1);
        check_eq("issue_rs2", pico_rs2, rs2);
        check_eq("issue_no_stb", 32'(res_STB), 32'd0);

        for (int i = 0; i < d; i++) begin
            pico_wait = 1'($urandom);
            cmd_STB   = 1'($urandom);
            @(negedge clk);
            if (e_to && i == TMO - 1) break;
            check_eq("wait_valid", 32'(pico_valid), 32'd1);
            check_eq("wait_insn", pico_insn, e_insn);
            check_eq("wait_rs1", pico_rs1, rs1);
            check_eq("wait_no_stb", 32'(res_STB), 32'd0);
        end
        cmd_STB = 1'b0;

        if (!e_to) begin
            pico_ready = 1'b1; pico_wr = wr; pico_rd = rdata;
            @(negedge clk);
            pico_ready = 1'b0; pico_wr = 1'($urandom); pico_rd = $urandom;
        end
        check_eq("done_valid_low", 32'(pico_valid), 32'd0);
        check_eq("done_stb", 32'(res_STB), 32'd1);
        check_eq("done_data", res_data, e_data);
        check_eq("done_rd", 32'(res_rd), 32'(rd));
        check_eq("done_wr", 32'(res_wr), 32'(e_wr));
        check_eq("done_err", 32'(res_err), 32'(e_err));

        for (int i = 0; i < ack_d; i++) begin
            cmd_STB = 1'($urandom);
            pico_ready = 1'($urandom);
            @(negedge clk);
            check_eq("hold_stb", 32'(res_STB), 32'd1);
            check_eq("hold_data", res_data, e_data);
            check_eq("hold_wr", 32'(res_wr), 32'(e_wr));
            check_eq("hold_busy", 32'(cmd_BUSY), 32'd1);
            check_eq("hold_valid", 32'(pico_valid), 32'd0);
        end
        cmd_STB = 1'b0; pico_ready = 1'b0;
        res_BUSY = 1'b1;
        @(negedge clk);
        res_BUSY = 1'b0;
        check_eq("ack_stb_low", 32'(res_STB), 32'd0);
        check_eq("ack_busy_low", 32'(cmd_BUSY), 32'd0);
        @(negedge clk);
        check_eq("idle_busy", 32'(cmd_BUSY), 32'd0);
        check_eq("idle_valid", 32'(pico_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: observed timeout, expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        rst = 1'b1; cmd_STB = 1'b0; cmd_funct3 = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        pico_wr = 1'b0; pico_rd = '0; pico_wait = 1'b0; pico_ready = 1'b0; res_BUSY = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        pico_ready = 1'b1; pico_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        pico_ready = 1'b0;
        check_eq("idle_ready_no_stb", 32'(res_STB), 32'd0);
        check_eq("idle_ready_data", res_data, 32'd0);

        run_txn(3'b001, 5'd5, 32'h0003_0004, 32'h0005_0006, 20, 1'b1, 32'h1234, 10, 1'b0);
        run_txn(3'b111, 5'd31, 32'hFFFF_0000, 32'h0000_FFFF, 3, 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
        run_txn(3'b000, 5'd0, 32'h1, 32'h2, 0, 1'b1, 32'h0, 1, 1'b0);
        run_txn(3'b010, 5'd9, 32'hA5A5_A5A5, 32'h5A5A_5A5A, TMO - 1, 1'b1, 32'hCAFE_0001, 2, 1'b0);
        run_txn(3'b100, 5'd17, 32'h1357_9BDF, 32'h2468_ACE0, TMO, 1'b1, 32'hCAFE_0002, 1, 1'b0);

        // Reset in the middle of a response wait must abort silently.
        cmd_STB = 1'b1; cmd_funct3 = 3'b011; cmd_rd = 5'd7; cmd_rs1 = 32'h11; cmd_rs2 = 32'h22;
        @(negedge clk);
        cmd_STB = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_valid", 32'(pico_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_stb", 32'(res_STB), 32'd0);
            check_eq("post_rst_no_valid", 32'(pico_valid), 32'd0);
        end
        run_txn(3'b101, 5'd12, 32'h0BAD_F00D, 32'h0000_0042, 4, 1'b1, 32'h7777_8888, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_txn(3'($urandom), 5'($urandom), $urandom, $urandom,
                    int'($urandom_range(20, 0)), 1'($urandom), $urandom,
                    int'($urandom_range(4, 0)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
